// File: rtl/mem_access_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_seq
//  Purpose  : Multi-cycle SRAM access sequencer for the SLC-3 datapath.
//             It accepts a single read or write request from the ISDU and
//             drives the active-low SRAM strobes, the MDR input select and
//             load, and the MDR tri-state enable. A one-cycle Done pulse
//             replaces fixed wait states in the ISDU.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_seq #(
   parameter int WAIT_STATES = 2
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Req_Read,
   input  logic Req_Write,
   output logic Done,
   output logic Busy,
   output logic Mem_CE,
   output logic Mem_UB,
   output logic Mem_LB,
   output logic Mem_OE,
   output logic Mem_WE,
   output logic MDR_Sel,
   output logic LD_MDR_Mem,
   output logic Data_Drive
);

   // Counter must hold WAIT_STATES; keep at least one bit when it is zero.
   localparam int CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      RD_LATCH = 3'd2,
      WR_SETUP = 3'd3,
      WR_PULSE = 3'd4,
      WR_HOLD  = 3'd5,
      DONE     = 3'd6
   } state_t;

   // All outputs live in one registered bundle so they switch glitch-free
   // together with the state register.
   typedef struct packed {
      logic done;
      logic busy;
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic mdr_sel;
      logic ld_mdr;
      logic drive;
   } strobes_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   strobes_t         strb;

   // Output decode for a given state. Reads own the bus through OE only,
   // writes through Data_Drive only, so the two never overlap.
   function automatic strobes_t decode(input state_t s);
      strobes_t o;
      o.done    = 1'b0;
      o.busy    = (s != IDLE);
      o.ce_n    = 1'b1;
      o.oe_n    = 1'b1;
      o.we_n    = 1'b1;
      o.mdr_sel = 1'b0;
      o.ld_mdr  = 1'b0;
      o.drive   = 1'b0;
      case (s)
         RD_WAIT: begin
            o.ce_n    = 1'b0;
            o.oe_n    = 1'b0;
            o.mdr_sel = 1'b1;
         end
         RD_LATCH: begin
            o.ce_n    = 1'b0;
            o.oe_n    = 1'b0;
            o.mdr_sel = 1'b1;
            o.ld_mdr  = 1'b1;
         end
         WR_SETUP: begin
            o.ce_n  = 1'b0;
            o.drive = 1'b1;
         end
         WR_PULSE: begin
            o.ce_n  = 1'b0;
            o.drive = 1'b1;
            o.we_n  = 1'b0;
         end
         WR_HOLD: begin
            o.ce_n  = 1'b0;
            o.drive = 1'b1;
         end
         DONE: begin
            o.done = 1'b1;
         end
         default: begin
         end
      endcase
      return o;
   endfunction

   // Next-state and counter logic; requests only matter in IDLE, and write
   // wins when both requests are high.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      case (state)
         IDLE: begin
            if (Req_Write) begin
               state_nxt = WR_SETUP;
            end else if (Req_Read) begin
               state_nxt = RD_WAIT;
               count_nxt = CNT_LOAD;
            end
         end
         RD_WAIT: begin
            if (count != '0) begin
               count_nxt = count - 1'b1;
            end else begin
               state_nxt = RD_LATCH;
            end
         end
         RD_LATCH: state_nxt = DONE;
         WR_SETUP: begin
            state_nxt = WR_PULSE;
            count_nxt = CNT_LOAD;
         end
         WR_PULSE: begin
            if (count != '0) begin
               count_nxt = count - 1'b1;
            end else begin
               state_nxt = WR_HOLD;
            end
         end
         WR_HOLD: state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, counter and registered outputs; reset aborts any access at once.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= IDLE;
         count <= '0;
         strb  <= decode(IDLE);
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         strb  <= decode(state_nxt);
      end
   end

   assign Done       = strb.done;
   assign Busy       = strb.busy;
   assign Mem_CE     = strb.ce_n;
   assign Mem_UB     = strb.ce_n;
   assign Mem_LB     = strb.ce_n;
   assign Mem_OE     = strb.oe_n;
   assign Mem_WE     = strb.we_n;
   assign MDR_Sel    = strb.mdr_sel;
   assign LD_MDR_Mem = strb.ld_mdr;
   assign Data_Drive = strb.drive;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_seq
//  Purpose  : Scoreboard bench for mem_access_seq. Instance A (2 wait states)
//             talks to a small SRAM/MDR model; instance B (0 wait states)
//             covers back-to-back handshakes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_seq;

   localparam int W_A = 2;
   localparam int W_B = 0;

   logic Clk = 1'b0;
   logic Reset;
   logic rd_a, wr_a, rd_b, wr_b;
   logic done_a, busy_a, ce_a, ub_a, lb_a, oe_a, we_a, sel_a, ld_a, dd_a;
   logic done_b, busy_b, ce_b, ub_b, lb_b, oe_b, we_b, sel_b, ld_b, dd_b;

   mem_access_seq #(.WAIT_STATES(W_A)) dut_a (
      .Clk(Clk), .Reset(Reset), .Req_Read(rd_a), .Req_Write(wr_a),
      .Done(done_a), .Busy(busy_a), .Mem_CE(ce_a), .Mem_UB(ub_a), .Mem_LB(lb_a),
      .Mem_OE(oe_a), .Mem_WE(we_a), .MDR_Sel(sel_a), .LD_MDR_Mem(ld_a),
      .Data_Drive(dd_a)
   );

   mem_access_seq #(.WAIT_STATES(W_B)) dut_b (
      .Clk(Clk), .Reset(Reset), .Req_Read(rd_b), .Req_Write(wr_b),
      .Done(done_b), .Busy(busy_b), .Mem_CE(ce_b), .Mem_UB(ub_b), .Mem_LB(lb_b),
      .Mem_OE(oe_b), .Mem_WE(we_b), .MDR_Sel(sel_b), .LD_MDR_Mem(ld_b),
      .Data_Drive(dd_b)
   );

   always #5 Clk = ~Clk;

   // ---------------- SRAM / MDR environment for instance A ----------------
   logic [15:0] sram [16];
   logic [3:0]  mar;
   logic [15:0] mdr;
   logic [15:0] cpu_data;
   logic        cpu_ld;
   logic        mem_init;

   function automatic logic [15:0] init_word(input int i);
      if (i == 5) return 16'h3A5C;
      return 16'(i * 16'h1111) ^ 16'h5A5A;
   endfunction

   wire [15:0] sram_dout = (!ce_a && !oe_a && we_a) ? sram[mar] : 16'h0000;
   wire [15:0] bus_wr    = dd_a ? mdr : 16'h0000;

   // SRAM array and MDR register behaviour
   always @(posedge Clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) sram[i] <= init_word(i);
      end else if (!ce_a && !we_a) begin
         sram[mar] <= bus_wr;
      end
      if (ld_a)        mdr <= sel_a ? sram_dout : cpu_data;
      else if (cpu_ld) mdr <= cpu_data;
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      int          kind;      // 1 read, 2 write
      int          done_cyc;
      int          addr;
      logic [15:0] data;
      bit          chk;
   } sb_t;

   sb_t         sbq_a[$];
   sb_t         sbq_b[$];
   logic [15:0] ref_mem [16];
   bit          ref_ok  [16];
   int          mk  [2];      // access kind in progress, 0 = idle
   int          mkk [2];      // cycle offset of the current cycle in that access
   int          m_addr;
   int          cyc   = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   // Access length in cycles after the accepting IDLE cycle, Done last.
   function automatic int acc_len(input int kind, input int w);
      return (kind == 1) ? w + 3 : w + 4;
   endfunction

   // Expected {done,busy,ce,ub,lb,oe,we,sel,ld,drive} from the latency rules.
   function automatic logic [9:0] exp_vec(input int kind, input int k, input int w);
      logic done, busy, ce, oe, we, sel, ld, dd;
      done = 1'b0; busy = 1'b0; ce = 1'b1; oe = 1'b1;
      we = 1'b1; sel = 1'b0; ld = 1'b0; dd = 1'b0;
      if (kind == 1) begin
         busy = 1'b1;
         if (k <= w + 2) begin ce = 1'b0; oe = 1'b0; sel = 1'b1; end
         ld   = (k == w + 2);
         done = (k == w + 3);
      end else if (kind == 2) begin
         busy = 1'b1;
         if (k <= w + 3) begin ce = 1'b0; dd = 1'b1; end
         we   = !(k >= 2 && k <= w + 2);
         done = (k == w + 4);
      end
      return {done, busy, ce, ce, ce, oe, we, sel, ld, dd};
   endfunction

   task automatic model_step(input int i, input logic rd, input logic wr, input int w);
      sb_t e;
      if (!Reset) begin
         if (mk[i] != 0 && mkk[i] < acc_len(mk[i], w)) begin
            if (i == 0) begin
               if (mk[i] == 2) ref_ok[m_addr] = 1'b0;
               void'(sbq_a.pop_back());
            end else begin
               void'(sbq_b.pop_back());
            end
         end
         mk[i] = 0; mkk[i] = 0;
      end else if (mk[i] != 0) begin
         mkk[i]++;
         if (mkk[i] > acc_len(mk[i], w)) begin mk[i] = 0; mkk[i] = 0; end
      end else if (rd || wr) begin
         e.kind     = wr ? 2 : 1;
         e.done_cyc = cyc + acc_len(e.kind, w);
         e.addr     = int'(mar);
         e.data     = 16'h0000;
         e.chk      = 1'b0;
         mk[i]  = e.kind;
         mkk[i] = 1;
         if (i == 0) begin
            m_addr = int'(mar);
            if (e.kind == 2) begin
               ref_mem[mar] = cpu_data;
               ref_ok[mar]  = 1'b1;
               e.data = cpu_data;
               e.chk  = 1'b1;
            end else begin
               e.data = ref_mem[mar];
               e.chk  = ref_ok[mar];
            end
            sbq_a.push_back(e);
         end else begin
            sbq_b.push_back(e);
         end
      end
   endtask

   // Model advances on every rising edge using the inputs seen at that edge
   always @(posedge Clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) begin
            ref_mem[i] = init_word(i);
            ref_ok[i]  = 1'b1;
         end
      end
      model_step(0, rd_a, wr_a, W_A);
      model_step(1, rd_b, wr_b, W_B);
      cyc++;
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle strobe check against the model, plus bus-contention check
   always @(posedge Clk) begin
      #1;
      cmp("strobes_a", 32'({done_a, busy_a, ce_a, ub_a, lb_a, oe_a, we_a, sel_a, ld_a, dd_a}),
          32'(exp_vec(mk[0], mkk[0], W_A)));
      cmp("strobes_b", 32'({done_b, busy_b, ce_b, ub_b, lb_b, oe_b, we_b, sel_b, ld_b, dd_b}),
          32'(exp_vec(mk[1], mkk[1], W_B)));
      cmp("contention_a", 32'(!oe_a && dd_a), 32'd0);
      cmp("contention_b", 32'(!oe_b && dd_b), 32'd0);
   end

   // Completion monitor: pops the scoreboard whenever a Done pulse appears
   always @(posedge Clk) begin
      sb_t e;
      #1;
      if (done_a === 1'b1) begin
         if (sbq_a.size() == 0) begin
            cmp("done_a_unexpected", 32'd1, 32'd0);
         end else begin
            e = sbq_a.pop_front();
            cmp("done_a_cycle", 32'(cyc), 32'(e.done_cyc));
            if (e.chk && e.kind == 1) cmp("read_data", 32'(mdr), 32'(e.data));
            if (e.chk && e.kind == 2) cmp("write_data", 32'(sram[e.addr]), 32'(e.data));
         end
      end
      if (done_b === 1'b1) begin
         if (sbq_b.size() == 0) begin
            cmp("done_b_unexpected", 32'd1, 32'd0);
         end else begin
            e = sbq_b.pop_front();
            cmp("done_b_cycle", 32'(cyc), 32'(e.done_cyc));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_done(input int which, output int at_cyc);
      at_cyc = -1;
      for (int n = 0; n < 60; n++) begin
         @(negedge Clk);
         if ((which == 0 ? done_a : done_b) === 1'b1) begin
            at_cyc = cyc;
            return;
         end
      end
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout_%0d: got no Done expected Done within 60 cycles", which);
   endtask

   // One access on instance A; kind 1 read, 2 write, 3 both requests
   task automatic do_access(input int kind, input logic [3:0] addr, input logic [15:0] data);
      int t;
      if (kind != 1) begin
         cpu_data = data;
         cpu_ld   = 1'b1;
         @(negedge Clk);
         cpu_ld   = 1'b0;
      end
      mar  = addr;
      rd_a = (kind != 2);
      wr_a = (kind != 1);
      wait_done(0, t);
      rd_a = 1'b0;
      wr_a = 1'b0;
   endtask

   initial begin
      int t, d1, d2, gap, kind;
      Reset = 1'b0; mem_init = 1'b1;
      rd_a = 1'b1; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
      mar = 4'd5; cpu_data = 16'h0000; cpu_ld = 1'b0;
      mk[0] = 0; mk[1] = 0; mkk[0] = 0; mkk[1] = 0; m_addr = 0;

      // Reset held two cycles with a read pending, then the read proceeds
      repeat (2) @(negedge Clk);
      mem_init = 1'b0;
      Reset    = 1'b1;
      wait_done(0, t);
      rd_a = 1'b0;
      @(negedge Clk);

      // Directed write, read-back, and simultaneous request
      do_access(2, 4'd9, 16'hBEEF);
      do_access(1, 4'd9, 16'h0000);
      repeat (2) @(negedge Clk);
      do_access(3, 4'd3, 16'h1234);
      @(negedge Clk);

      // Reset during cycle 3 of a write aborts with no Done
      cpu_data = 16'hDEAD; cpu_ld = 1'b1;
      @(negedge Clk);
      cpu_ld = 1'b0; mar = 4'd12; wr_a = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0; wr_a = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      repeat (3) @(negedge Clk);

      // Randomised accesses with random idle gaps
      for (int n = 0; n < 120; n++) begin
         kind = int'($urandom_range(1, 3));
         do_access(kind, 4'($urandom_range(0, 15)), 16'($urandom));
         gap = int'($urandom_range(0, 3));
         repeat (gap) @(negedge Clk);
      end
      @(negedge Clk);

      // Instance B: back-to-back reads with the request held through Done
      rd_b = 1'b1;
      wait_done(1, d1);
      wait_done(1, d2);
      rd_b = 1'b0;
      cmp("b2b_done_spacing", 32'(d2 - d1), 32'd4);
      repeat (2) @(negedge Clk);
      wr_b = 1'b1;
      wait_done(1, t);
      wr_b = 1'b0;
      repeat (4) @(negedge Clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Multi-cycle SRAM access sequencer for the SLC-3 datapath.
- The ISDU issues a single read or write request. This block drives the SRAM strobes (CE/OE/WE/UB/LB, all active-low), the MDR input-select and MDR load, and the SRAM data-bus tri-state enable.
- It returns a one-cycle Done pulse, replacing fixed "wait" states in the ISDU with a handshake.
- Address comes from MAR and is outside this block.

Parameters:
- WAIT_STATES, 2, extra cycles the SRAM access is held (0..15). Counter width = max(1, $clog2(WAIT_STATES+1)).

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on rising edge of Clk.
- Req_Read  input  1  read request from ISDU; held until Done seen.
- Req_Write  input  1  write request from ISDU; held until Done seen.
- Done  output  1  one-cycle completion pulse.
- Busy  output  1  high whenever state != IDLE.
- Mem_CE  output  1  SRAM chip enable, active-low.
- Mem_UB  output  1  upper byte enable, active-low; equals Mem_CE.
- Mem_LB  output  1  lower byte enable, active-low; equals Mem_CE.
- Mem_OE  output  1  SRAM output enable, active-low.
- Mem_WE  output  1  SRAM write enable, active-low.
- MDR_Sel  output  1  MDR input mux: 1 = SRAM data, 0 = CPU bus.
- LD_MDR_Mem  output  1  MDR load strobe for read data; ORed with ISDU's LD_MDR externally.
- Data_Drive  output  1  enables MDR tri-state onto SRAM data bus.

Behaviour:
- Moore FSM; all outputs decoded from registered state only.
- States: IDLE, RD_WAIT, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Reset (Reset=0 at rising edge):
  - state=IDLE, counter=0.
  - Mem_CE=Mem_UB=Mem_LB=Mem_OE=Mem_WE=1.
  - Done=Busy=MDR_Sel=LD_MDR_Mem=Data_Drive=0.
  - Reset mid-access aborts at that edge with no further strobes. The partial write is not retried.
- IDLE:
  - Req_Write=1 -> WR_SETUP. Write has priority if both requests are high.
  - Else Req_Read=1 -> RD_WAIT.
  - Entering RD_WAIT or WR_PULSE loads counter=WAIT_STATES.
- RD_WAIT:
  - Mem_CE=0, Mem_OE=0, MDR_Sel=1.
  - If counter!=0, decrement; else -> RD_LATCH. Lasts WAIT_STATES+1 cycles.
- RD_LATCH:
  - Mem_CE=0, Mem_OE=0, MDR_Sel=1, LD_MDR_Mem=1 (one cycle) -> DONE.
- WR_SETUP:
  - Mem_CE=0, Data_Drive=1, Mem_WE=1 (address/data setup) -> WR_PULSE.
  - Counter loads WAIT_STATES.
- WR_PULSE:
  - Mem_CE=0, Data_Drive=1, Mem_WE=0.
  - Counts down exactly as RD_WAIT (WAIT_STATES+1 cycles) -> WR_HOLD.
- WR_HOLD:
  - Mem_CE=0, Data_Drive=1, Mem_WE=1 (data hold) -> DONE.
- DONE:
  - Done=1, all strobes inactive, Busy=1 -> IDLE unconditionally.
- Mem_OE=0 and Data_Drive=1 are never simultaneously true (bus contention forbidden). Mem_WE=0 only in WR_PULSE.
- Latency, with request first high in IDLE cycle 0:
  - Read: Done in cycle WAIT_STATES+3. LD_MDR_Mem in cycle WAIT_STATES+2.
  - Write: Done in cycle WAIT_STATES+4.
- Handshake:
  - Requests are ignored outside IDLE.
  - The requester deasserts its request in the cycle Done=1. A request still high in the following IDLE cycle starts a new access; this is legal back-to-back.
  - Request changes during an access have no effect.
- WAIT_STATES=0: RD_WAIT and WR_PULSE last exactly 1 cycle. Read Done at cycle 3, write Done at cycle 4.

Test Plan:
- Reset behaviour: hold Reset=0 two cycles with Req_Read=1 -> all active-low strobes =1, Done=Busy=0, state stays IDLE. Release Reset -> read starts next cycle.
- Read (W=2): Req_Read=1 at cycle 0 with the SRAM model returning 16'h3A5C ->
  - Mem_OE=0 in cycles 1-4.
  - LD_MDR_Mem=1 only in cycle 4, and MDR captures 16'h3A5C.
  - Done=1 only in cycle 5.
  - Data_Drive=0 throughout.
- Write (W=2): Req_Write=1 with MDR=16'hBEEF ->
  - Data_Drive=1 in cycles 1-5.
  - Mem_WE=0 in cycles 2-4 only.
  - Done in cycle 6.
  - SRAM model holds 16'hBEEF at MAR address.
- Simultaneous Req_Read=Req_Write=1 in IDLE -> write sequence taken; Mem_OE stays 1 for the whole access.
- Reset mid-write: Reset=0 at cycle 3 of a write -> at that edge Mem_WE=1, Data_Drive=0, state IDLE; no Done pulse.
- Back-to-back with W=0: hold Req_Read=1 through Done -> second read starts the cycle after Done; second Done 4 cycles after the first. Checker asserts no OE/Data_Drive overlap across the whole run.
